// File: rtl/fpu_raise_align.sv
// FP exception-flag alignment stage: delays per-channel raise flags to line up
// with retire, accumulates sticky flags and raises a held trap request.
module fpu_raise_align #(
  parameter int unsigned NCH    = 6,
  parameter int unsigned FLAG_W = 11,
  parameter int unsigned RET_W  = 14,
  parameter int unsigned LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           fpcsr,
  input  logic [NCH*FLAG_W-1:0] raise_s,
  input  logic [NCH-1:0]        raise_vld,
  input  logic [NCH*RET_W-1:0]  ret_in,
  input  logic [NCH-1:0]        ret_en_in,
  output logic [NCH*RET_W-1:0]  ret,
  output logic [NCH-1:0]        ret_en,
  output logic [NCH-1:0]        ret_exc,
  output logic [FLAG_W-1:0]     sticky,
  input  logic                  csr_wr,
  input  logic                  csr_clr,
  input  logic [FLAG_W-1:0]     csr_wdata,
  output logic                  trap_req,
  output logic [2:0]            trap_ch,
  output logic [FLAG_W-1:0]     trap_flags,
  input  logic                  trap_ack,
  output logic [7:0]            orphan_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state, state_nxt;

  logic              dly_vld   [NCH][LAT];
  logic [FLAG_W-1:0] dly_flags [NCH][LAT];

  logic [FLAG_W-1:0] enables;
  logic [FLAG_W-1:0] en_flags [NCH];
  logic [FLAG_W-1:0] new_flags;
  logic [NCH-1:0]    exc_nxt;
  logic              any_orphan;
  logic              trap_hit;
  logic [2:0]        sel_ch;
  logic [FLAG_W-1:0] sel_flags;
  logic              capture;
  logic              unused_fpcsr;

  assign enables      = fpcsr[FLAG_W-1:0];
  assign unused_fpcsr = ^fpcsr;
  assign trap_req     = (state == PEND);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rst) begin
        for (int unsigned j = 0; j < LAT; j++) begin
          dly_vld[i][j]   <= 1'b0;
          dly_flags[i][j] <= '0;
        end
      end else begin
        dly_vld[i][0]   <= raise_vld[i];
        dly_flags[i][0] <= raise_s[i*FLAG_W +: FLAG_W];
        for (int unsigned j = 1; j < LAT; j++) begin
          dly_vld[i][j]   <= dly_vld[i][j-1];
          dly_flags[i][j] <= dly_flags[i][j-1];
        end
      end
    end
  end

  // Match on the delay-line tail; the lowest trapping channel wins the capture.
  always_comb begin
    new_flags  = '0;
    exc_nxt    = '0;
    any_orphan = 1'b0;
    trap_hit   = 1'b0;
    sel_ch     = '0;
    sel_flags  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      logic [FLAG_W-1:0] m;
      m           = (dly_vld[i][LAT-1] & ret_en_in[i]) ? dly_flags[i][LAT-1] : '0;
      en_flags[i] = m & enables;
      new_flags   = new_flags | m;
      exc_nxt[i]  = ret_en_in[i] & (|en_flags[i]);
      any_orphan  = any_orphan | (dly_vld[i][LAT-1] & ~ret_en_in[i]);
      if (!trap_hit && (|en_flags[i])) begin
        trap_hit  = 1'b1;
        sel_ch    = 3'(i);
        sel_flags = en_flags[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (trap_hit) begin
        state_nxt = PEND;
        capture   = 1'b1;
      end
      PEND: if (trap_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ret        <= '0;
      ret_en     <= '0;
      ret_exc    <= '0;
      sticky     <= '0;
      trap_ch    <= '0;
      trap_flags <= '0;
      orphan_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ret     <= ret_in;
      ret_en  <= ret_en_in;
      ret_exc <= exc_nxt;
      if (csr_wr)       sticky <= csr_wdata | new_flags;
      else if (csr_clr) sticky <= new_flags;
      else              sticky <= sticky | new_flags;
      if (any_orphan && orphan_cnt != 8'hFF) orphan_cnt <= orphan_cnt + 8'd1;
      if (capture) begin
        trap_ch    <= sel_ch;
        trap_flags <= sel_flags;
      end
    end
  end

endmodule

// File: tb/tb_fpu_raise_align.sv
// Directed self-checking bench for fpu_raise_align (NCH=6, FLAG_W=11, RET_W=14, LAT=2).
module tb_fpu_raise_align;

  localparam int unsigned NCH = 6, FW = 11, RW = 14, LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     fpcsr;
  logic [NCH*FW-1:0] raise_s;
  logic [NCH-1:0]  raise_vld;
  logic [NCH*RW-1:0] ret_in;
  logic [NCH-1:0]  ret_en_in;
  logic [NCH*RW-1:0] ret;
  logic [NCH-1:0]  ret_en, ret_exc;
  logic [FW-1:0]   sticky, csr_wdata, trap_flags;
  logic            csr_wr, csr_clr, trap_req, trap_ack;
  logic [2:0]      trap_ch;
  logic [7:0]      orphan_cnt;

  int unsigned n_checks = 0, n_pass = 0;

  fpu_raise_align #(.NCH(NCH), .FLAG_W(FW), .RET_W(RW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .fpcsr(fpcsr), .raise_s(raise_s), .raise_vld(raise_vld),
    .ret_in(ret_in), .ret_en_in(ret_en_in), .ret(ret), .ret_en(ret_en), .ret_exc(ret_exc),
    .sticky(sticky), .csr_wr(csr_wr), .csr_clr(csr_clr), .csr_wdata(csr_wdata),
    .trap_req(trap_req), .trap_ch(trap_ch), .trap_flags(trap_flags), .trap_ack(trap_ack),
    .orphan_cnt(orphan_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 0; raise_s = '0; raise_vld = '0; ret_in = '0; ret_en_in = '0;
    csr_wr = 0; csr_clr = 0; csr_wdata = '0; trap_ack = 0;
  endtask

  // Raise flags on the masked channels, then retire them LAT cycles later with
  // optional CSR/ack activity in the retire cycle. Returns just after the retire edge.
  task automatic matched(input logic [NCH-1:0] mask, input logic [FW-1:0] flags,
                         input logic clr, input logic wr, input logic [FW-1:0] wdata,
                         input logic ack);
    for (int unsigned i = 0; i < NCH; i++)
      if (mask[i]) raise_s[i*FW +: FW] = flags;
    raise_vld = mask;
    tick();
    raise_vld = '0; raise_s = '0;
    repeat (LAT-1) tick();
    ret_en_in = mask;
    for (int unsigned i = 0; i < NCH; i++) ret_in[i*RW +: RW] = RW'(14'h100 + i);
    csr_clr = clr; csr_wr = wr; csr_wdata = wdata; trap_ack = ack;
    tick();
    clear_in();
  endtask

  initial begin
    clear_in();
    fpcsr = '0;
    rst = 1;
    tick(); tick();
    check("rst_ret_en", 32'(ret_en), 0);
    check("rst_sticky", 32'(sticky), 0);
    check("rst_trap_req", 32'(trap_req), 0);
    check("rst_orphan", 32'(orphan_cnt), 0);
    rst = 0;

    // 1: basic alignment, no enables
    matched(6'b000001, 11'h004, 0, 0, '0, 0);
    check("t1_ret_en", 32'(ret_en), 32'h01);
    check("t1_ret0", 32'(ret[RW-1:0]), 32'h100);
    check("t1_sticky", 32'(sticky), 32'h004);
    check("t1_exc", 32'(ret_exc), 0);
    check("t1_trap_req", 32'(trap_req), 0);

    // 2: simultaneous traps on ch3 and ch1, lowest wins
    fpcsr = 32'h004;
    matched(6'b001010, 11'h004, 0, 0, '0, 0);
    check("t2_trap_req", 32'(trap_req), 1);
    check("t2_trap_ch", 32'(trap_ch), 1);
    check("t2_trap_flags", 32'(trap_flags), 32'h004);
    check("t2_exc", 32'(ret_exc), 32'b001010);
    tick();
    check("t2_hold_req", 32'(trap_req), 1);
    check("t2_hold_ch", 32'(trap_ch), 1);

    // 3: trapping retire while pending is not queued
    fpcsr = 32'h005;
    matched(6'b000100, 11'h001, 0, 0, '0, 0);
    check("t3_trap_ch", 32'(trap_ch), 1);
    check("t3_trap_flags", 32'(trap_flags), 32'h004);
    check("t3_sticky", 32'(sticky), 32'h005);
    check("t3_exc", 32'(ret_exc), 32'b000100);
    trap_ack = 1;
    tick();
    trap_ack = 0;
    check("t3_ack_req", 32'(trap_req), 0);
    tick();
    check("t3_after_req", 32'(trap_req), 0);
    trap_ack = 1;
    tick();
    trap_ack = 0;
    check("t3_idle_ack", 32'(trap_req), 0);

    // 4: CSR clear/write alongside retiring flags
    fpcsr = '0;
    csr_wr = 1; csr_wdata = 11'h0F0;
    tick();
    clear_in();
    check("t4_wr", 32'(sticky), 32'h0F0);
    matched(6'b000001, 11'h002, 1, 0, '0, 0);
    check("t4_clr_new", 32'(sticky), 32'h002);
    matched(6'b000001, 11'h001, 1, 1, 11'h100, 0);
    check("t4_wr_clr_new", 32'(sticky), 32'h101);

    // 5: orphans
    raise_vld = 6'b010000; raise_s[4*FW +: FW] = 11'h080;
    tick();
    clear_in();
    repeat (LAT) tick();
    check("t5_orphan1", 32'(orphan_cnt), 1);
    check("t5_sticky", 32'(sticky), 32'h101);
    raise_vld = '1; raise_s = '1;
    tick();
    clear_in();
    repeat (LAT) tick();
    check("t5_orphan_multi", 32'(orphan_cnt), 2);
    raise_vld = '1;
    repeat (300) tick();
    clear_in();
    repeat (LAT + 1) tick();
    check("t5_orphan_sat", 32'(orphan_cnt), 255);
    check("t5_sticky_sat", 32'(sticky), 32'h101);

    // 6: reset mid-flight discards the queued raise
    fpcsr = 32'h008;
    raise_vld = 6'b000001; raise_s[FW-1:0] = 11'h008;
    tick();
    clear_in();
    rst = 1;
    tick();
    rst = 0;
    ret_en_in = 6'b000001;
    tick();
    clear_in();
    check("t6_ret_en", 32'(ret_en), 32'h01);
    check("t6_sticky", 32'(sticky), 0);
    check("t6_orphan", 32'(orphan_cnt), 0);
    check("t6_exc", 32'(ret_exc), 0);
    check("t6_trap_req", 32'(trap_req), 0);

    // 7: trapping retire in the ack cycle is only recorded in sticky
    fpcsr = 32'h004;
    matched(6'b100000, 11'h004, 0, 0, '0, 0);
    check("t7_trap_ch", 32'(trap_ch), 5);
    check("t7_trap_req", 32'(trap_req), 1);
    matched(6'b000001, 11'h004, 0, 0, '0, 1);
    check("t7_ack_req", 32'(trap_req), 0);
    check("t7_sticky", 32'(sticky), 32'h004);
    tick();
    check("t7_no_recapture", 32'(trap_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
